pe_output_deskew: RTL and testbench

//   Receiving end of the PE array's bottom-edge result bus. Takes the raw skewed per-column

---
 rtl/pe_output_deskew.sv | 201 ++++++++++++++++++++
 tb/tb_pe_output_deskew.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_output_deskew.sv
// pe_output_deskew
// Re-aligns the skewed bottom-edge result bus of the PE array (column j lags
// column 0 by j cycles). Aligned rows are tagged with a row index and an
// end-of-tile marker, then buffered in a first-word fall-through FIFO that is
// drained over valid/ready. The array cannot stall, so a row that finds the
// FIFO full is dropped and the sticky overflow flag is raised.
// COLS must be at least 2 and FIFO_DEPTH must be a power of two >= ROWS.

module pe_output_deskew #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       clear,
  input  logic                                       in_valid,
  input  logic [COLS*2*DATA_WIDTH-1:0]               in_data,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [COLS*2*DATA_WIDTH-1:0]               out_data,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
  output logic                                       out_last,
  output logic                                       busy,
  output logic                                       tile_done,
  output logic                                       overflow
);

  localparam int LW = 2 * DATA_WIDTH;                      // one result lane
  localparam int BW = COLS * LW;                           // whole row
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;       // row index
  localparam int AW = $clog2(FIFO_DEPTH);                  // FIFO pointer
  localparam int CW = AW + 1;                              // FIFO occupancy
  localparam int EW = BW + RW + 1;                         // {last, row, data}

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  // Deskew delay lines
  logic [LW-1:0]   aligned_s [COLS];
  logic [COLS-2:0] vld_r;
  logic            row_valid_s;
  logic [BW-1:0]   row_data_s;

  // FIFO
  logic [EW-1:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   cnt_r;
  logic [EW-1:0]   head_s;
  logic            fifo_nonempty_s;

  // Control
  state_t          state_r;
  logic [RW-1:0]   row_cnt_r;
  logic            row_last_s;
  logic            push_try_s;
  logic            push_ok_s;
  logic            pop_s;
  logic            drop_s;
  logic            tile_done_r;
  logic            overflow_r;

  // Lane j waits COLS-1-j stages so every lane of a row lines up with lane COLS-1.
  for (genvar j = 0; j < COLS; j++) begin : g_lane
    localparam int DEPTH = COLS - 1 - j;
    if (DEPTH == 0) begin : g_direct
      assign aligned_s[j] = in_data[j*LW +: LW];
    end else begin : g_delay
      logic [LW-1:0] lane_r [DEPTH];

      // Free-running lane shift register, flushed by clear.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) lane_r[i] <= '0;
        end else if (clear) begin
          for (int i = 0; i < DEPTH; i++) lane_r[i] <= '0;
        end else begin
          lane_r[0] <= in_data[j*LW +: LW];
          for (int i = 1; i < DEPTH; i++) lane_r[i] <= lane_r[i-1];
        end
      end

      assign aligned_s[j] = lane_r[DEPTH-1];
    end
  end

  // Column-0 valid follows the longest lane so it marks the fully aligned row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= '0;
    end else if (clear) begin
      vld_r <= '0;
    end else begin
      vld_r[0] <= in_valid;
      for (int i = 1; i < COLS - 1; i++) vld_r[i] <= vld_r[i-1];
    end
  end

  assign row_valid_s = vld_r[COLS-2];

  // Pack aligned lanes back into the bus layout.
  always_comb begin
    row_data_s = '0;
    for (int j = 0; j < COLS; j++) row_data_s[j*LW +: LW] = aligned_s[j];
  end

  assign fifo_nonempty_s = (cnt_r != '0);
  assign head_s          = mem_r[rd_ptr_r];

  // Write/pop arbitration; a full FIFO still accepts when the head leaves this cycle.
  always_comb begin
    row_last_s = (row_cnt_r == RW'(ROWS - 1));
    push_try_s = row_valid_s && !clear;
    pop_s      = fifo_nonempty_s && out_ready && !clear;
    if (cnt_r < CW'(FIFO_DEPTH)) begin
      push_ok_s = push_try_s;
    end else if (pop_s) begin
      push_ok_s = push_try_s;
    end else begin
      push_ok_s = 1'b0;
    end
    drop_s = push_try_s && !push_ok_s;
  end

  // Row storage; contents are only observed through the gated head outputs.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= {row_last_s, row_cnt_r, row_data_s};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)     rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Tile FSM and row counter; dropped rows still consume a row index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      row_cnt_r <= '0;
    end else if (clear) begin
      state_r   <= ST_IDLE;
      row_cnt_r <= '0;
    end else if (row_valid_s) begin
      row_cnt_r <= row_last_s ? '0 : row_cnt_r + RW'(1);
      case (state_r)
        ST_IDLE:    state_r <= row_last_s ? ST_IDLE : ST_COLLECT;
        ST_COLLECT: state_r <= row_last_s ? ST_IDLE : ST_COLLECT;
        default:    state_r <= ST_IDLE;
      endcase
    end else begin
      state_r   <= state_r;
      row_cnt_r <= row_cnt_r;
    end
  end

  // End-of-tile pulse after the last row is taken, and the sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_done_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (clear) begin
      tile_done_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      tile_done_r <= pop_s && head_s[EW-1];
      if (drop_s) overflow_r <= 1'b1;
    end
  end

  // Outputs decode flops only; the head is masked so an empty FIFO reads as zero.
  assign out_valid = fifo_nonempty_s;
  assign out_data  = fifo_nonempty_s ? head_s[BW-1:0]  : '0;
  assign out_row   = fifo_nonempty_s ? head_s[BW +: RW] : '0;
  assign out_last  = fifo_nonempty_s && head_s[EW-1];
  assign busy      = (state_r != ST_IDLE) || (|vld_r) || fifo_nonempty_s;
  assign tile_done = tile_done_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_pe_output_deskew.sv
// Bench for pe_output_deskew: directed skewed tiles, expected rows queued at
// issue time, a negedge monitor pops and compares on every handshake.

module tb_pe_output_deskew;

  localparam int DW = 8;
  localparam int R  = 8;
  localparam int C  = 8;
  localparam int FD = 16;
  localparam int BW = C * 2 * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic [BW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic [2:0]    out_row;
  logic          out_last;
  logic          busy;
  logic          tile_done;
  logic          overflow;

  pe_output_deskew #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_last(out_last), .busy(busy), .tile_done(tile_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] data;
    logic [2:0]    row;
    logic          last;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   td_cyc = -1;
  logic prev_last = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Result element of row r, column j in a tile identified by tag.
  function automatic logic [15:0] elem(input int tag, input int r, input int j);
    if (tag == 0 && r == 7 && j == 7) return 16'hFFFF;
    return 16'(tag * 4096 + r * 16 + j);
  endfunction

  function automatic logic [BW-1:0] row_vec(input int tag, input int r);
    logic [BW-1:0] v;
    v = '0;
    for (int j = 0; j < C; j++) v[j*16 +: 16] = elem(tag, r, j);
    return v;
  endfunction

  // Skewed feed of nrows back-to-back rows; the first nkeep are expected out.
  task automatic feed_rows(input int tag, input int nrows, input int nkeep,
                           input bit timed, output int t0);
    logic [BW-1:0] v;
    exp_t e;
    t0 = 0;
    for (int k = 0; k < nrows + C - 1; k++) begin
      @(posedge clk); #1;
      if (k == 0) t0 = cyc;
      in_valid = (k < nrows);
      v = '0;
      for (int j = 0; j < C; j++) begin
        if (k - j >= 0 && k - j < nrows) v[j*16 +: 16] = elem(tag, k - j, j);
      end
      in_data = v;
      if (k < nrows && k < nkeep) begin
        e.data = row_vec(tag, k);
        e.row  = 3'(k % R);
        e.last = ((k % R) == R - 1);
        e.cyc  = timed ? t0 + k + C : -1;
        sb.push_back(e);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(posedge clk); #2;
      n++;
    end
    chk(name, sb.size(), 0);
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_out_valid"}, out_valid, 1'b0);
    chk({p, "_out_data"},  out_data,  '0);
    chk({p, "_out_row"},   out_row,   3'd0);
    chk({p, "_out_last"},  out_last,  1'b0);
    chk({p, "_busy"},      busy,      1'b0);
    chk({p, "_tile_done"}, tile_done, 1'b0);
    chk({p, "_overflow"},  overflow,  1'b0);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  // Monitor: compares every handshake against the queue and checks tile_done.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_last = 1'b0;
    end else begin
      if (prev_last || tile_done) chk("tile_done", tile_done, prev_last);
      if (tile_done) td_cyc = cyc;
      prev_last = 1'b0;
      if (!clear && out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_row: actual row=%0d data=%0h, required no row", out_row, out_data);
        end else begin
          e = sb.pop_front();
          chk("row_data", out_data, e.data);
          chk("row_index", out_row, e.row);
          chk("row_last", out_last, e.last);
          if (e.cyc >= 0) chk("row_latency", cyc, e.cyc);
          prev_last = e.last;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    int t0;
    int tx;
    int bad;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("in_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_zero("after_reset");

    // 1: one tile, sink always ready, exact latency and tile_done timing
    out_ready = 1'b1;
    td_cyc = -1;
    feed_rows(0, 8, 8, 1'b1, t0);
    wait_drain("t1_drain", 40);
    repeat (2) @(posedge clk);
    #1;
    chk("t1_tile_done_cycle", td_cyc, t0 + 16);
    chk("t1_overflow", overflow, 1'b0);

    // 2: backpressure holds the head stable, then drains one row per cycle
    out_ready = 1'b0;
    feed_rows(2, 8, 8, 1'b0, tx);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (!(out_valid && out_data == row_vec(2, 0) && out_row == 3'd0)) bad++;
    end
    chk("t2_hold_stable", bad, 0);
    chk("t2_busy_held", busy, 1'b1);
    out_ready = 1'b1;
    repeat (7) @(posedge clk);
    #2;
    chk("t2_one_left", sb.size(), 1);
    chk("t2_busy_before_last", busy, 1'b1);
    @(posedge clk); #2;
    chk("t2_drained", sb.size(), 0);
    chk("t2_busy_after_last", busy, 1'b0);
    chk("t2_overflow", overflow, 1'b0);

    // 3: three tiles into a stalled sink, last eight rows dropped
    out_ready = 1'b0;
    feed_rows(1, 24, 16, 1'b0, tx);
    chk("t3_overflow_set", overflow, 1'b1);
    chk("t3_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    wait_drain("t3_drain", 40);
    chk("t3_overflow_sticky", overflow, 1'b1);
    pulse_clear();
    chk("t3_overflow_cleared", overflow, 1'b0);

    // 4: full FIFO with a pop in the row_valid cycle accepts the new row
    out_ready = 1'b0;
    feed_rows(2, 16, 16, 1'b0, tx);
    fork
      feed_rows(3, 1, 1, 1'b0, tx);
      begin
        repeat (8) @(posedge clk);
        #1;
        out_ready = 1'b1;
        chk("t4_full_valid", out_valid, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("t4_no_overflow", overflow, 1'b0);
      end
    join
    out_ready = 1'b1;
    wait_drain("t4_drain", 40);
    chk("t4_overflow_end", overflow, 1'b0);
    pulse_clear();

    // 5: reset with four rows buffered, next tile restarts at row 0
    out_ready = 1'b0;
    feed_rows(4, 4, 0, 1'b0, tx);
    chk("t5_pre_valid", out_valid, 1'b1);
    chk("t5_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_zero("t5_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    feed_rows(5, 8, 8, 1'b0, tx);
    wait_drain("t5_drain", 40);

    // 6: clear in a row_valid cycle with five rows buffered
    out_ready = 1'b0;
    fork
      feed_rows(6, 6, 0, 1'b0, tx);
      begin
        repeat (13) @(posedge clk);
        #1;
        clear = 1'b1;
        chk("t6_pre_valid", out_valid, 1'b1);
        @(posedge clk); #1;
        clear = 1'b0;
        chk_zero("t6_clear");
      end
    join
    out_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) bad++;
    end
    chk("t6_no_ghost", bad, 0);
    feed_rows(7, 8, 8, 1'b0, tx);
    wait_drain("t6_drain", 40);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
